adxl362_spi_responder: RTL and testbench
========================================

# adxl362_spi_responder

SPI-slave behavioural stand-in for the ADXL362 accelerometer on the PmodACL2 connector. It decodes the 0x0A register-write and 0x0B register-read instructions, keeps a 64-byte register map, and returns 12-bit X/Y/Z samples supplied by the testbench or a motion generator. It sits on the far end of the four-wire SPI bus driven by the accelerometer front-end, so that front-end can be exercised on-board or in simulation without the physical part. All SPI inputs are oversampled in the `Clock` domain.

## Interface
- `CLK_PER_HALF`, default 4: minimum `Clock` cycles per SCLK high or low phase. Documentation only; it is not used in logic.
- `Clock` in 1: system clock.
- `Reset` in 1: asynchronous, active-low reset.
- `SCLK` in 1: SPI clock, mode 0 (CPOL=0, CPHA=0), MSB first.
- `MOSI` in 1: SPI data from the master.
- `CS` in 1: chip select, active low.
- `MISO` out 1: SPI data to the master.
- `sample_x`, `sample_y`, `sample_z` in 12 each: two's-complement acceleration.
- `sample_valid` in 1: one-cycle load strobe for the three samples.
- `power_ctl` out 8: contents of register 0x2D.
- `wr_strobe` out 1: one-cycle pulse per completed write byte.
- `wr_addr` out 6: address of that write byte.
- `wr_data` out 8: data of that write byte.
- `busy` out 1: synchronised CS is low.

## Operation
- **Synchronisers.** `SCLK`, `MOSI` and `CS` each pass through two flops.
  - Edges are detected on the synchronised SCLK and CS.
  - All decoding uses the synchronised signals only.
- **Register map.**
  - Reads: 0x00=0xAD, 0x01=0x1D, 0x02=0xF2.
  - Sample registers:
    - 0x0E = X[7:0]; 0x0F = {4×X[11], X[11:8]}.
    - 0x10/0x11 hold Y in the same layout.
    - 0x12/0x13 hold Z in the same layout.
  - 0x20–0x2F is a writable 16-byte array; 0x2D within it is `power_ctl`.
  - All other addresses read 0x00 and ignore writes.
- **Sample shadow.**
  - A `sample_valid` strobe with `busy`=0 loads the shadow registers directly.
  - A strobe with `busy`=1 is held in a one-deep pending buffer; a newer strobe overwrites the pending value.
  - The pending value is applied on the cycle after CS rises.
  - A read burst therefore always sees a coherent triple.
- **State machine.** States are IDLE, CMD, ADDR, WR, RD and SKIP.
  - CS falling: go to CMD; bit counter = 0.
  - On each SCLK rising edge, shift in MOSI. After the 8th bit:
    - CMD with 0x0A → WR; with 0x0B → RD via ADDR; any other value → SKIP.
    - ADDR: latch the 6-bit address. Bits [7:6] are ignored.
    - WR: write the byte to the register map, pulse `wr_strobe`, then increment the address.
    - RD: increment the address and preload the next byte.
  - CS rising from any state → IDLE. A partially received byte is discarded with no write.
  - SKIP consumes all remaining SCLK edges with no effect.
- **Address wrap.** The address auto-increments and wraps from 0x3F to 0x00.
- **MISO.**
  - MISO is 0 in IDLE, CMD, ADDR, SKIP and WR.
  - In RD, the register byte is loaded when the address byte (or the previous data byte) completes.
  - Its bit 7 is driven on the next SCLK falling edge.
  - Each following falling edge shifts out the next bit.

## Timing
- Reset values:
  - `MISO`=0, `power_ctl`=0x00, `wr_strobe`=0, `wr_addr`=0, `wr_data`=0, `busy`=0.
  - Writable array and shadow registers are all zero; no sample is pending; state is IDLE.
- Edge-to-action latency: 3 `Clock` cycles, made up of 2 synchroniser flops and 1 edge-detect flop.
- The master must hold SCLK high and low for at least `CLK_PER_HALF` cycles each.
- The master must hold CS low for at least 4 cycles before the first SCLK rise.
- `wr_strobe` goes high 1 cycle after the detected 8th rising edge of a data byte. `wr_addr` and `wr_data` are valid in the same cycle.
- `power_ctl` updates in that same cycle.
- On simultaneous events, a CS rise takes priority over an SCLK edge.

## Structure
- Shared package holds:
  - Instruction constants: 0x0A, 0x0B.
  - Register addresses: DEVID 0x00–0x02, XDATA_L 0x0E, writable base 0x20, POWER_CTL 0x2D.
  - ID values and state encodings.
- One sub-module, `spi_pin_sync`: a two-flop synchroniser with rise/fall outputs. It is instantiated for SCLK and CS; MOSI uses the synchroniser only.

## Test plan
- Write burst: write 0x2D=0x02 → `wr_strobe` pulses once with addr 0x2D, data 0x02; `power_ctl`=0x02.
- Read burst: read from 0x00 for 3 bytes → MISO returns 0xAD, 0x1D, 0xF2.
- Sample read:
  - Load X=0x812, Y=0x07F, Z=0xFFF.
  - Read 0x0E for 6 bytes → 0x12, 0xF8, 0x7F, 0x00, 0xFF, 0xFF.
- Coherence: a `sample_valid` strobe mid-burst does not change the bytes in that burst; the next burst returns the new values.
- Wrap and abort:
  - Write 2 bytes starting at 0x3F → the second write lands at 0x00 and is ignored.
  - CS rising after 5 bits of a write → no `wr_strobe`.
- Unknown command 0x0D: the following bytes are ignored, MISO stays 0, and registers are unchanged.

Source files
------------

// File: rtl/adxl362_spi_responder_pkg.sv
// Shared constants, state encoding and sample payload for the ADXL362 SPI stand-in.
package adxl362_spi_responder_pkg;

  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned ADDR_W    = 6;
  localparam int unsigned SAMPLE_W  = 12;
  localparam int unsigned ARR_DEPTH = 16;

  localparam logic [BYTE_W-1:0] INSTR_WRITE = 8'h0A;
  localparam logic [BYTE_W-1:0] INSTR_READ  = 8'h0B;

  localparam logic [ADDR_W-1:0] ADDR_DEVID_AD  = 6'h00;
  localparam logic [ADDR_W-1:0] ADDR_DEVID_MST = 6'h01;
  localparam logic [ADDR_W-1:0] ADDR_PARTID    = 6'h02;
  localparam logic [ADDR_W-1:0] ADDR_XDATA_L   = 6'h0E;
  localparam logic [ADDR_W-1:0] ADDR_WR_BASE   = 6'h20;
  localparam logic [ADDR_W-1:0] ADDR_POWER_CTL = 6'h2D;

  localparam logic [BYTE_W-1:0] ID_DEVID_AD  = 8'hAD;
  localparam logic [BYTE_W-1:0] ID_DEVID_MST = 8'h1D;
  localparam logic [BYTE_W-1:0] ID_PARTID    = 8'hF2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_WR,
    ST_RD,
    ST_SKIP
  } state_t;

  typedef struct packed {
    logic [SAMPLE_W-1:0] x;
    logic [SAMPLE_W-1:0] y;
    logic [SAMPLE_W-1:0] z;
  } sample_t;

  // Byte idx of the XL/XH/YL/YH/ZL/ZH block; high bytes are sign-extended.
  function automatic logic [BYTE_W-1:0] sample_byte(input sample_t s, input logic [2:0] idx);
    logic [SAMPLE_W-1:0] w_axis;
    w_axis = idx[2] ? s.z : (idx[1] ? s.y : s.x);
    return idx[0] ? {{4{w_axis[SAMPLE_W-1]}}, w_axis[SAMPLE_W-1:8]} : w_axis[7:0];
  endfunction

endpackage

// File: rtl/adxl362_spi_responder_sync.sv
// Two-flop synchroniser with a delay flop for rising/falling edge detection.
module spi_pin_sync #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_pin,
  output logic o_rise_c,
  output logic o_fall_c
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
      r_prev <= RESET_VAL;
    end else begin
      r_meta <= i_pin;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_rise_c = r_sync & ~r_prev;
  assign o_fall_c = ~r_sync & r_prev;

endmodule

// File: rtl/adxl362_spi_responder.sv
// Behavioural SPI-slave model of the ADXL362: register map, write/read bursts, sample shadow.
module adxl362_spi_responder
  import adxl362_spi_responder_pkg::*;
#(
  parameter int unsigned CLK_PER_HALF = 4
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                SCLK,
  input  logic                MOSI,
  input  logic                CS,
  output logic                MISO,
  input  logic [SAMPLE_W-1:0] sample_x,
  input  logic [SAMPLE_W-1:0] sample_y,
  input  logic [SAMPLE_W-1:0] sample_z,
  input  logic                sample_valid,
  output logic [BYTE_W-1:0]   power_ctl,
  output logic                wr_strobe,
  output logic [ADDR_W-1:0]   wr_addr,
  output logic [BYTE_W-1:0]   wr_data,
  output logic                busy
);

  if (CLK_PER_HALF < 2) begin : g_bad_half
    $error("CLK_PER_HALF must be at least 2");
  end

  logic w_sclk_rise;
  logic w_sclk_fall;
  logic w_cs_rise;
  logic w_cs_fall;

  spi_pin_sync #(.RESET_VAL(1'b0)) u_sclk_sync (
    .clk      (Clock),
    .rst_n    (Reset),
    .i_pin    (SCLK),
    .o_rise_c (w_sclk_rise),
    .o_fall_c (w_sclk_fall)
  );

  spi_pin_sync #(.RESET_VAL(1'b1)) u_cs_sync (
    .clk      (Clock),
    .rst_n    (Reset),
    .i_pin    (CS),
    .o_rise_c (w_cs_rise),
    .o_fall_c (w_cs_fall)
  );

  logic r_mosi_meta;
  logic r_mosi_sync;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_mosi_meta <= 1'b0;
      r_mosi_sync <= 1'b0;
    end else begin
      r_mosi_meta <= MOSI;
      r_mosi_sync <= r_mosi_meta;
    end
  end

  state_t              r_state;
  state_t              w_state_nxt;
  logic [2:0]          r_bit_cnt;
  logic [BYTE_W-2:0]   r_shift;
  logic                r_is_read;
  logic [ADDR_W-1:0]   r_addr;
  logic [BYTE_W-1:0]   r_tx;
  logic [BYTE_W-1:0]   r_arr [ARR_DEPTH];
  sample_t             r_shadow;
  sample_t             r_pending;
  logic                r_pend;

  logic [BYTE_W-1:0]   w_byte;
  logic                w_byte_done;
  logic                w_shift_en;
  logic                w_set_dir;
  logic                w_latch_addr;
  logic                w_preload;
  logic                w_addr_inc;
  logic                w_do_write;
  logic                w_tx_shift;
  logic                w_miso_clr;
  logic [ADDR_W-1:0]   w_rd_addr;
  logic [ADDR_W-1:0]   w_rd_off;
  logic [BYTE_W-1:0]   w_rd_byte;
  sample_t             w_sample_in;

  assign w_byte      = {r_shift, r_mosi_sync};
  assign w_byte_done = w_sclk_rise && (r_bit_cnt == 3'd7) &&
                       (r_state inside {ST_CMD, ST_ADDR, ST_WR, ST_RD});
  assign w_sample_in = '{x: sample_x, y: sample_y, z: sample_z};

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // CS rise beats CS fall beats any SCLK activity.
  always_comb begin
    w_state_nxt = r_state;
    if (w_cs_rise) begin
      w_state_nxt = ST_IDLE;
    end else if (w_cs_fall) begin
      w_state_nxt = ST_CMD;
    end else if (w_byte_done) begin
      case (r_state)
        ST_CMD:  w_state_nxt = (w_byte == INSTR_WRITE || w_byte == INSTR_READ) ? ST_ADDR : ST_SKIP;
        ST_ADDR: w_state_nxt = r_is_read ? ST_RD : ST_WR;
        default: w_state_nxt = r_state;
      endcase
    end
  end

  always_comb begin
    w_shift_en   = 1'b0;
    w_set_dir    = 1'b0;
    w_latch_addr = 1'b0;
    w_preload    = 1'b0;
    w_addr_inc   = 1'b0;
    w_do_write   = 1'b0;
    w_tx_shift   = 1'b0;
    w_miso_clr   = 1'b1;
    if (!w_cs_rise && !w_cs_fall) begin
      w_shift_en = w_sclk_rise && (r_state != ST_IDLE);
      w_miso_clr = (r_state != ST_RD);
      case (r_state)
        ST_CMD:  w_set_dir = w_byte_done;
        ST_ADDR: begin
          w_latch_addr = w_byte_done;
          w_preload    = w_byte_done && r_is_read;
        end
        ST_WR: begin
          w_do_write = w_byte_done;
          w_addr_inc = w_byte_done;
        end
        ST_RD: begin
          w_preload  = w_byte_done;
          w_addr_inc = w_byte_done;
          w_tx_shift = w_sclk_fall;
        end
        default: begin
        end
      endcase
    end
  end

  // Read-ahead address: the freshly received address, or the next one in a burst.
  assign w_rd_addr = (r_state == ST_ADDR) ? w_byte[ADDR_W-1:0] : ADDR_W'(r_addr + 6'd1);
  assign w_rd_off  = ADDR_W'(w_rd_addr - ADDR_XDATA_L);

  always_comb begin
    w_rd_byte = '0;
    if (w_rd_addr == ADDR_DEVID_AD)
      w_rd_byte = ID_DEVID_AD;
    else if (w_rd_addr == ADDR_DEVID_MST)
      w_rd_byte = ID_DEVID_MST;
    else if (w_rd_addr == ADDR_PARTID)
      w_rd_byte = ID_PARTID;
    else if (w_rd_off < 6'd6)
      w_rd_byte = sample_byte(r_shadow, w_rd_off[2:0]);
    else if (w_rd_addr[5:4] == ADDR_WR_BASE[5:4])
      w_rd_byte = r_arr[w_rd_addr[3:0]];
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_is_read <= 1'b0;
      r_addr    <= '0;
      r_tx      <= '0;
      MISO      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      if (w_cs_rise)      busy <= 1'b0;
      else if (w_cs_fall) busy <= 1'b1;

      if (w_cs_fall)       r_bit_cnt <= '0;
      else if (w_shift_en) r_bit_cnt <= 3'(r_bit_cnt + 3'd1);

      if (w_shift_en) r_shift   <= w_byte[BYTE_W-2:0];
      if (w_set_dir)  r_is_read <= (w_byte == INSTR_READ);

      if (w_latch_addr)    r_addr <= w_byte[ADDR_W-1:0];
      else if (w_addr_inc) r_addr <= ADDR_W'(r_addr + 6'd1);

      if (w_preload)       r_tx <= w_rd_byte;
      else if (w_tx_shift) r_tx <= {r_tx[BYTE_W-2:0], 1'b0};

      if (w_miso_clr)      MISO <= 1'b0;
      else if (w_tx_shift) MISO <= r_tx[BYTE_W-1];
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < int'(ARR_DEPTH); i++) r_arr[i] <= '0;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
    end else begin
      wr_strobe <= w_do_write;
      if (w_do_write) begin
        wr_addr <= r_addr;
        wr_data <= w_byte;
        if (r_addr[5:4] == ADDR_WR_BASE[5:4]) r_arr[r_addr[3:0]] <= w_byte;
      end
    end
  end

  assign power_ctl = r_arr[ADDR_POWER_CTL[3:0]];

  // Strobes during a burst wait in the pending slot so a burst reads one coherent triple.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_shadow  <= '0;
      r_pending <= '0;
      r_pend    <= 1'b0;
    end else if (sample_valid && !busy) begin
      r_shadow <= w_sample_in;
      r_pend   <= 1'b0;
    end else if (sample_valid) begin
      r_pending <= w_sample_in;
      r_pend    <= 1'b1;
    end else if (r_pend && !busy) begin
      r_shadow <= r_pending;
      r_pend   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_adxl362_spi_responder.sv
// Directed bench for adxl362_spi_responder: drives SPI mode-0 bursts and checks bytes/strobes.
module tb_adxl362_spi_responder;

  localparam int HALF = 8;

  logic        Clock;
  logic        Reset;
  logic        SCLK;
  logic        MOSI;
  logic        CS;
  logic        MISO;
  logic [11:0] sample_x;
  logic [11:0] sample_y;
  logic [11:0] sample_z;
  logic        sample_valid;
  logic [7:0]  power_ctl;
  logic        wr_strobe;
  logic [5:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        busy;

  int total = 0;
  int bad   = 0;
  int strobe_cnt = 0;
  logic [5:0] log_addr [64];
  logic [7:0] log_data [64];
  logic [7:0] rd [8];
  logic [7:0] rx;

  adxl362_spi_responder #(.CLK_PER_HALF(4)) dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .SCLK         (SCLK),
    .MOSI         (MOSI),
    .CS           (CS),
    .MISO         (MISO),
    .sample_x     (sample_x),
    .sample_y     (sample_y),
    .sample_z     (sample_z),
    .sample_valid (sample_valid),
    .power_ctl    (power_ctl),
    .wr_strobe    (wr_strobe),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .busy         (busy)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  always @(negedge Clock) begin
    if (wr_strobe === 1'b1) begin
      if (strobe_cnt < 64) begin
        log_addr[strobe_cnt] = wr_addr;
        log_data[strobe_cnt] = wr_data;
      end
      strobe_cnt = strobe_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge Clock);
  endtask

  task automatic cs_start();
    CS = 1'b0;
    clks(8);
  endtask

  task automatic cs_end();
    clks(4);
    CS = 1'b1;
    clks(10);
  endtask

  task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] r);
    r = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      MOSI = tx[7-i];
      clks(HALF);
      r = {r[6:0], MISO};
      SCLK = 1'b1;
      clks(HALF);
      SCLK = 1'b0;
    end
  endtask

  task automatic read_burst(input logic [7:0] a, input int n);
    logic [7:0] d;
    cs_start();
    xfer(8'h0B, 8, d);
    xfer(a, 8, d);
    for (int i = 0; i < n; i++) xfer(8'h00, 8, rd[i]);
    cs_end();
  endtask

  task automatic pulse_sample(input logic [11:0] x, input logic [11:0] y, input logic [11:0] z);
    sample_x = x;
    sample_y = y;
    sample_z = z;
    sample_valid = 1'b1;
    clks(1);
    sample_valid = 1'b0;
    clks(1);
  endtask

  initial begin
    Reset = 1'b0;
    SCLK = 1'b0;
    MOSI = 1'b0;
    CS = 1'b1;
    sample_x = '0;
    sample_y = '0;
    sample_z = '0;
    sample_valid = 1'b0;
    clks(4);

    // reset state
    check("rst_miso", 32'(MISO), 32'h0);
    check("rst_power_ctl", 32'(power_ctl), 32'h00);
    check("rst_wr_strobe", 32'(wr_strobe), 32'h0);
    check("rst_wr_addr", 32'(wr_addr), 32'h00);
    check("rst_wr_data", 32'(wr_data), 32'h00);
    check("rst_busy", 32'(busy), 32'h0);
    Reset = 1'b1;
    clks(6);

    // write 0x2D = 0x02
    cs_start();
    check("busy_low_cs", 32'(busy), 32'h1);
    xfer(8'h0A, 8, rx);
    check("wr_cmd_miso", 32'(rx), 32'h00);
    xfer(8'h2D, 8, rx);
    xfer(8'h02, 8, rx);
    check("wr_data_miso", 32'(rx), 32'h00);
    cs_end();
    check("busy_idle", 32'(busy), 32'h0);
    check("wr_strobe_cnt", 32'(strobe_cnt), 32'd1);
    check("wr_addr_2d", 32'(log_addr[0]), 32'h2D);
    check("wr_data_02", 32'(log_data[0]), 32'h02);
    check("power_ctl_02", 32'(power_ctl), 32'h02);

    // ID registers
    read_burst(8'h00, 3);
    check("rd_devid_ad", 32'(rd[0]), 32'hAD);
    check("rd_devid_mst", 32'(rd[1]), 32'h1D);
    check("rd_partid", 32'(rd[2]), 32'hF2);

    // writable array round trip
    cs_start();
    xfer(8'h0A, 8, rx);
    xfer(8'h20, 8, rx);
    xfer(8'hA5, 8, rx);
    xfer(8'h5A, 8, rx);
    cs_end();
    check("arr_strobe_cnt", 32'(strobe_cnt), 32'd3);
    check("arr_wr_addr_21", 32'(log_addr[2]), 32'h21);
    read_burst(8'h20, 2);
    check("rd_arr_20", 32'(rd[0]), 32'hA5);
    check("rd_arr_21", 32'(rd[1]), 32'h5A);

    // samples loaded while idle
    pulse_sample(12'h812, 12'h07F, 12'hFFF);
    read_burst(8'h0E, 6);
    check("rd_xl", 32'(rd[0]), 32'h12);
    check("rd_xh", 32'(rd[1]), 32'hF8);
    check("rd_yl", 32'(rd[2]), 32'h7F);
    check("rd_yh", 32'(rd[3]), 32'h00);
    check("rd_zl", 32'(rd[4]), 32'hFF);
    check("rd_zh", 32'(rd[5]), 32'hFF);

    // coherence: strobes mid-burst must not disturb it
    cs_start();
    xfer(8'h0B, 8, rx);
    xfer(8'h0E, 8, rx);
    xfer(8'h00, 8, rd[0]);
    xfer(8'h00, 8, rd[1]);
    pulse_sample(12'h111, 12'h222, 12'h333);
    pulse_sample(12'h345, 12'h123, 12'h7FF);
    for (int i = 2; i < 6; i++) xfer(8'h00, 8, rd[i]);
    cs_end();
    check("coh_xl", 32'(rd[0]), 32'h12);
    check("coh_xh", 32'(rd[1]), 32'hF8);
    check("coh_yl", 32'(rd[2]), 32'h7F);
    check("coh_yh", 32'(rd[3]), 32'h00);
    check("coh_zl", 32'(rd[4]), 32'hFF);
    check("coh_zh", 32'(rd[5]), 32'hFF);
    read_burst(8'h0E, 6);
    check("new_xl", 32'(rd[0]), 32'h45);
    check("new_xh", 32'(rd[1]), 32'h03);
    check("new_yl", 32'(rd[2]), 32'h23);
    check("new_yh", 32'(rd[3]), 32'h01);
    check("new_zl", 32'(rd[4]), 32'hFF);
    check("new_zh", 32'(rd[5]), 32'h07);

    // address wrap on write and read
    cs_start();
    xfer(8'h0A, 8, rx);
    xfer(8'h3F, 8, rx);
    xfer(8'h55, 8, rx);
    xfer(8'h66, 8, rx);
    cs_end();
    check("wrap_strobe_cnt", 32'(strobe_cnt), 32'd5);
    check("wrap_addr_3f", 32'(log_addr[3]), 32'h3F);
    check("wrap_addr_00", 32'(log_addr[4]), 32'h00);
    check("wrap_data_66", 32'(log_data[4]), 32'h66);
    read_burst(8'h3F, 2);
    check("rd_wrap_3f", 32'(rd[0]), 32'h00);
    check("rd_wrap_00", 32'(rd[1]), 32'hAD);

    // abort after 5 bits of a data byte
    cs_start();
    xfer(8'h0A, 8, rx);
    xfer(8'h2D, 8, rx);
    xfer(8'hFF, 5, rx);
    cs_end();
    check("abort_strobe_cnt", 32'(strobe_cnt), 32'd5);
    check("abort_power_ctl", 32'(power_ctl), 32'h02);

    // unknown command: everything after it is ignored
    cs_start();
    xfer(8'h0D, 8, rx);
    check("unk_cmd_miso", 32'(rx), 32'h00);
    xfer(8'h2D, 8, rx);
    check("unk_b1_miso", 32'(rx), 32'h00);
    xfer(8'hFF, 8, rx);
    check("unk_b2_miso", 32'(rx), 32'h00);
    cs_end();
    check("unk_strobe_cnt", 32'(strobe_cnt), 32'd5);
    check("unk_power_ctl", 32'(power_ctl), 32'h02);
    read_burst(8'h2C, 3);
    check("rd_2c", 32'(rd[0]), 32'h00);
    check("rd_2d", 32'(rd[1]), 32'h02);
    check("rd_2e", 32'(rd[2]), 32'h00);
    check("idle_miso", 32'(MISO), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
